// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word accesses to a 32-bit registered-address RAM.
// Sub-word stores are done as read-modify-write, and loads are lane-extracted and extended.
// Misaligned or illegal-size requests complete with an error and never touch the RAM.

// One byte lane of the read-modify-write merge: take the store byte when enabled,
// otherwise keep the byte read from RAM.
module lsu_byte_lane (
  input  logic       be,
  input  logic [7:0] wbyte,
  input  logic [7:0] rbyte,
  output logic [7:0] mbyte
);
  assign mbyte = be ? wbyte : rbyte;
endmodule

module load_store_unit #(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        ram_wren,
  output logic [29:0] ram_address,
  output logic [31:0] ram_data,
  input  logic [31:0] ram_q
);
  localparam int NUM_LANES = 4;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_CAP  = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_RESP = 3'd4;

  logic [2:0]  state, state_nxt;
  logic        we_q, sgn_q;
  logic [1:0]  size_q, off_q;
  logic [31:0] wdata_q;

  logic        accept, misaligned;
  logic [4:0]  shamt;
  logic [1:0]  lane_idx;
  logic [NUM_LANES-1:0] be;
  logic [31:0] lane_data, load_ext, wdata_pl, merged;

  assign req_ready = (state == S_IDLE);
  assign accept    = req_valid & req_ready;
  assign rsp_valid = (state == S_RESP);

  // Alignment check on the incoming request; size 11 is always an error.
  always_comb begin
    misaligned = 1'b0;
    case (req_size)
      2'b01:   misaligned = req_addr[0];
      2'b10:   misaligned = |req_addr[1:0];
      2'b11:   misaligned = 1'b1;
      default: misaligned = 1'b0;
    endcase
  end

  // Bit position of the addressed lane inside the RAM word, from the latched offset.
  always_comb begin
    shamt = 5'd0;
    case (size_q)
      2'b00:   shamt = BIG_ENDIAN ? {~off_q, 3'b000} : {off_q, 3'b000};
      2'b01:   shamt = BIG_ENDIAN ? {~off_q[1], 4'b0000} : {off_q[1], 4'b0000};
      default: shamt = 5'd0;
    endcase
  end

  assign lane_idx  = shamt[4:3];
  assign lane_data = ram_q >> shamt;
  assign wdata_pl  = wdata_q << shamt;

  // Byte enables of the store lane(s) and sign/zero extension of the load lane.
  always_comb begin
    be       = '0;
    load_ext = lane_data;
    case (size_q)
      2'b00: begin
        be       = 4'b0001 << lane_idx;
        load_ext = {{24{sgn_q & lane_data[7]}}, lane_data[7:0]};
      end
      2'b01: begin
        be       = 4'b0011 << lane_idx;
        load_ext = {{16{sgn_q & lane_data[15]}}, lane_data[15:0]};
      end
      default: begin
        be       = 4'b1111;
        load_ext = lane_data;
      end
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      lsu_byte_lane u_lane (
        .be    (be[gi]),
        .wbyte (wdata_pl[8*gi +: 8]),
        .rbyte (ram_q[8*gi +: 8]),
        .mbyte (merged[8*gi +: 8])
      );
    end
  endgenerate

  // RAM write port is a pure decode of state so reset kills a write instantly.
  assign ram_wren = (state == S_WR) | ((state == S_CAP) & we_q);
  assign ram_data = (state == S_WR) ? wdata_q :
                    ((state == S_CAP) & we_q) ? merged : 32'd0;

  // Next-state selection.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept)
                state_nxt = misaligned ? S_RESP :
                            (req_we && req_size == 2'b10) ? S_WR : S_RD;
      S_RD:   state_nxt = S_CAP;
      S_CAP:  state_nxt = S_RESP;
      S_WR:   state_nxt = S_RESP;
      S_RESP: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register, request latch and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      we_q        <= 1'b0;
      sgn_q       <= 1'b0;
      size_q      <= 2'b00;
      off_q       <= 2'b00;
      wdata_q     <= 32'd0;
      ram_address <= 30'd0;
      rsp_rdata   <= 32'd0;
      rsp_err     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        we_q        <= req_we;
        sgn_q       <= req_signed;
        size_q      <= req_size;
        off_q       <= req_addr[1:0];
        wdata_q     <= req_wdata;
        ram_address <= req_addr[31:2];
        rsp_err     <= misaligned;
        rsp_rdata   <= 32'd0;
      end else if (state == S_CAP && !we_q) begin
        rsp_rdata <= load_ext;
      end
    end
  end
endmodule
